// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings and constants for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int STRB_W = 4;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering, load extraction/extension and access legality
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic [31:0]       wdata_st,
  input  logic [1:0]        ld_lane,
  input  logic [2:0]        ld_funct3,
  input  logic [31:0]       rdata,
  output logic [31:0]       rdata_ext,
  output logic              illegal
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        bad_f3;
  logic        misalign;
  // load uses the lane/size latched at issue; store and check use the live request
  always_comb begin
    ld_byte   = 8'(rdata >> {ld_lane, 3'b000});
    ld_half   = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    rdata_ext = ld_funct3 == F3_B  ? {{24{ld_byte[7]}}, ld_byte} :
                ld_funct3 == F3_BU ? {24'b0, ld_byte} :
                ld_funct3 == F3_H  ? {{16{ld_half[15]}}, ld_half} :
                ld_funct3 == F3_HU ? {16'b0, ld_half} : rdata;
    wstrb     = funct3 == F3_B ? 4'b0001 << lane :
                funct3 == F3_H ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_st  = funct3 == F3_B ? {4{wdata[7:0]}} :
                funct3 == F3_H ? {2{wdata[15:0]}} : wdata;
    bad_f3    = mem_write ? !(funct3 inside {F3_B, F3_H, F3_W}) :
                            !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign  = (funct3 == F3_H || funct3 == F3_HU) ? lane[0] :
                funct3 == F3_W ? |lane : 1'b0;
    illegal   = (mem_read | mem_write) & ((mem_read & mem_write) | bad_f3 | misalign);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage running a req/ack handshake with data memory
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic [2:0]            funct3_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  stall_o,
  output logic                  err_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [STRB_W-1:0]     mem_wstrb_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ack_i
);
  lsu_state_t        state;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic              load_q;
  logic [STRB_W-1:0] wstrb;
  logic [31:0]       wdata_st;
  logic [31:0]       rdata_ext;
  logic              illegal;
  logic              access;

  lsu_align u_align (
    .lane      (addr_i[1:0]),
    .funct3    (funct3_i),
    .mem_read  (mem_read_i),
    .mem_write (mem_write_i),
    .wdata     (wdata_i),
    .wstrb     (wstrb),
    .wdata_st  (wdata_st),
    .ld_lane   (lane_q),
    .ld_funct3 (f3_q),
    .rdata     (mem_rdata_i),
    .rdata_ext (rdata_ext),
    .illegal   (illegal)
  );

  assign access  = mem_read_i | mem_write_i;
  assign stall_o = !rst && ((state == IDLE && access && !illegal) || state == BUSY);

  // handshake FSM with registered request fields, load result and error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      f3_q        <= '0;
      lane_q      <= '0;
      load_q      <= 1'b0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wstrb_o <= '0;
      mem_wdata_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: if (access) begin
          if (illegal) err_o <= 1'b1;
          else begin
            state       <= BUSY;
            f3_q        <= funct3_i;
            lane_q      <= addr_i[1:0];
            load_q      <= mem_read_i;
            mem_req_o   <= 1'b1;
            mem_we_o    <= mem_write_i;
            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb_o <= mem_write_i ? wstrb : '0;
            mem_wdata_o <= wdata_st;
          end
        end
        BUSY: if (mem_ack_i) begin
          state       <= DONE;
          mem_req_o   <= 1'b0;
          mem_we_o    <= 1'b0;
          mem_wstrb_o <= '0;
          if (load_q) rdata_o <= rdata_ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for the load/store unit handshake and data path
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_i = '0, wdata_i = '0, mem_rdata_i = '0;
  logic        mem_read_i = 1'b0, mem_write_i = 1'b0, mem_ack_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_wstrb_o;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_rdata = '0;
  int          n_checks = 0, n_fail = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .addr_i(addr_i), .wdata_i(wdata_i),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .funct3_i(funct3_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .err_o(err_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (lane == 2'd2) ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [1:0] lane);
    case (f3)
      3'b000: return (lane == 0) ? 4'b0001 : (lane == 1) ? 4'b0010 : (lane == 2) ? 4'b0100 : 4'b1000;
      3'b001: return (lane == 2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      3'b001: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int dly);
    exp_t e;
    int   stalls = 0;
    e.addr  = {a[31:2], 2'b00};
    e.we    = wr;
    e.strb  = wr ? model_strb(f3, a[1:0]) : 4'b0000;
    e.wdata = model_wdata(f3, wd);
    e.rdata = rd ? model_load(f3, a[1:0], word) : last_rdata;
    last_rdata = e.rdata;
    sb.push_back(e);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = wd;
    #1;
    chk("idle_stall", {31'b0, stall_o}, 1);
    stalls += int'(stall_o);
    @(posedge clk) #1;
    e = sb.pop_front();
    for (int w = 0; w <= dly; w++) begin
      chk("busy_req", {31'b0, mem_req_o}, 1);
      chk("busy_addr", mem_addr_o, e.addr);
      chk("busy_we", {31'b0, mem_we_o}, {31'b0, e.we});
      chk("busy_strb", {28'b0, mem_wstrb_o}, {28'b0, e.strb});
      chk("busy_wdata", mem_wdata_o, e.wdata);
      stalls += int'(stall_o);
      mem_ack_i   = (w == dly);
      mem_rdata_i = (w == dly) ? word : ~word;
      @(posedge clk) #1;
    end
    mem_ack_i = 1'b0; mem_rdata_i = '0; mem_read_i = 1'b0; mem_write_i = 1'b0;
    #1;
    chk("done_stall", {31'b0, stall_o}, 0);
    chk("done_req", {31'b0, mem_req_o}, 0);
    chk("done_we", {31'b0, mem_we_o}, 0);
    chk("done_strb", {28'b0, mem_wstrb_o}, 0);
    chk("done_rdata", rdata_o, e.rdata);
    chk("stall_cycles", 32'(stalls), 32'(dly + 2));
    @(posedge clk) #1;
    chk("idle_req", {31'b0, mem_req_o}, 0);
    chk("idle_rdata_hold", rdata_o, e.rdata);
  endtask

  task automatic bad_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a;
    #1;
    chk("err_stall", {31'b0, stall_o}, 0);
    @(posedge clk) #1;
    chk("err_pulse", {31'b0, err_o}, 1);
    chk("err_no_req", {31'b0, mem_req_o}, 0);
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(posedge clk) #1;
    chk("err_clear", {31'b0, err_o}, 0);
    chk("err_no_req2", {31'b0, mem_req_o}, 0);
    chk("err_stall2", {31'b0, stall_o}, 0);
  endtask

  initial begin
    mem_read_i = 1'b1; funct3_i = 3'b010;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'b0, stall_o}, 0);
    chk("rst_req", {31'b0, mem_req_o}, 0);
    chk("rst_we", {31'b0, mem_we_o}, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_strb", {28'b0, mem_wstrb_o}, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_err", {31'b0, err_o}, 0);
    mem_read_i = 1'b0; rst = 1'b0;
    @(posedge clk) #1;
    access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    access(1, 0, 3'b000, 32'h203, 32'h0, 32'h80112233, 1);
    access(1, 0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0);
    access(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 32'h0, 0);
    access(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2);
    access(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_7FFF, 0);
    access(1, 0, 3'b000, 32'h011, 32'h0, 32'h0000_7F00, 0);
    access(1, 0, 3'b001, 32'h020, 32'h0, 32'h1234_F00D, 0);
    access(0, 1, 3'b000, 32'h001, 32'h1234_565A, 32'h0, 2);
    access(0, 1, 3'b010, 32'h500, 32'hCAFE_F00D, 32'h0, 3);
    bad_access(1, 0, 3'b010, 32'h101);
    bad_access(1, 1, 3'b010, 32'h100);
    bad_access(1, 0, 3'b101, 32'h103);
    bad_access(0, 1, 3'b100, 32'h100);
    bad_access(1, 0, 3'b011, 32'h100);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    @(posedge clk) #1;
    mem_ack_i = 1'b0;
    chk("idle_ack_req", {31'b0, mem_req_o}, 0);
    chk("idle_ack_rdata", rdata_o, last_rdata);
    mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h400;
    @(posedge clk) #1;
    chk("rb_busy1_req", {31'b0, mem_req_o}, 1);
    @(posedge clk) #1;
    chk("rb_busy2_req", {31'b0, mem_req_o}, 1);
    rst = 1'b1;
    #1;
    chk("rb_rst_stall", {31'b0, stall_o}, 0);
    @(posedge clk) #1;
    chk("rb_req_after_rst", {31'b0, mem_req_o}, 0);
    rst = 1'b0; mem_read_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    @(posedge clk) #1;
    mem_ack_i = 1'b0; last_rdata = '0;
    chk("rb_late_ack_req", {31'b0, mem_req_o}, 0);
    chk("rb_late_ack_stall", {31'b0, stall_o}, 0);
    chk("rb_rdata", rdata_o, last_rdata);
    @(posedge clk) #1;
    chk("rb_rdata_hold", rdata_o, last_rdata);
    access(1, 0, 3'b010, 32'h600, 32'h0, 32'h0BAD_CAFE, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage directly downstream of the ALU in the RV32I core. It takes the ALU result as the effective address and the second register operand as store data, and runs a req/ack handshake with data memory. It performs byte-lane steering and write strobes for stores, and sign/zero extension for loads. It stalls the core while an access is outstanding and flags misaligned or illegal accesses without issuing them.

Parameters:
DATA_WIDTH, 32, datapath and memory word width (only 32 supported)
ADDR_WIDTH, 32, byte address width

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous active-high reset
addr_i  in  ADDR_WIDTH  effective byte address (ALU output)
wdata_i  in  DATA_WIDTH  store data (rs2), value in low bits
mem_read_i  in  1  current instruction is a load
mem_write_i  in  1  current instruction is a store
funct3_i  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
rdata_o  out  DATA_WIDTH  extended load result, valid in DONE
stall_o  out  1  hold PC and pipeline inputs
err_o  out  1  one-cycle pulse: misaligned or illegal access
mem_req_o  out  1  memory request, held until ack
mem_we_o  out  1  write enable for the request
mem_addr_o  out  ADDR_WIDTH  word-aligned address, addr_i with [1:0] forced to 0
mem_wstrb_o  out  4  byte write strobes
mem_wdata_o  out  DATA_WIDTH  lane-steered store data
mem_rdata_i  in  DATA_WIDTH  raw memory word
mem_ack_i  in  1  memory completes the access this cycle

Behaviour:
- FSM states IDLE, BUSY, DONE. Reset state is IDLE. All mem_* outputs, rdata_o and err_o are registered, and all reset to 0. stall_o is combinational and is 0 while rst is high.
- IDLE: if mem_read_i or mem_write_i is high and the access is legal, register the address, strobes and steered data, set mem_req_o=1 and mem_we_o=mem_write_i, then go to BUSY. stall_o=1 in this cycle.
- Illegal access: H with addr[0]=1, W with addr[1:0]≠0, funct3 outside the legal set for the access type (stores allow only 000/001/010), or read and write both high. Response: no request, err_o=1 for the next cycle only, stall_o=0, FSM stays IDLE.
- BUSY: mem_req_o and all request fields stay stable and stall_o=1 until mem_ack_i. On ack: drop mem_req_o, mem_we_o and mem_wstrb_o; for loads capture extended data into rdata_o; go to DONE. An ack in the first BUSY cycle is legal.
- DONE: stall_o=0 and rdata_o is valid, so the core advances at this edge. Next state is IDLE. rdata_o holds its value until the next load completes.
- Minimum access takes 3 cycles: IDLE, BUSY with ack, DONE. Each additional ack-wait cycle adds one BUSY cycle.
- Load extraction (lane = addr[1:0]):
  - B: byte lane, sign-extended. BU: byte lane, zero-extended.
  - H: halfword at lane 0 or 2, sign-extended. HU: same lane, zero-extended.
  - W: whole word.
- Store steering:
  - SB: wstrb = 0001 shifted left by lane; byte replicated to all lanes.
  - SH: wstrb 0011 at lane 0 or 1100 at lane 2; halfword replicated to both halves.
  - SW: wstrb 1111.
- mem_ack_i is ignored in IDLE and DONE.
- rst asserted in BUSY: next state IDLE and mem_req_o=0 at that edge. Any late ack is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum lsu_state_t {IDLE, BUSY, DONE}
  - the byte-strobe width constant
- One combinational sub-module, lsu_align, handles the data path: store steering and strobe generation, load extraction and extension, and the misalign/illegal check. The FSM and registers stay in load_store_unit.

Test Plan:
- LW addr 0x100, memory word 0xDEADBEEF, ack in first BUSY cycle -> stall_o high 2 cycles, rdata_o=0xDEADBEEF in DONE, mem_addr_o=0x100, mem_we_o=0.
- LB addr 0x203, word 0x80112233 -> rdata_o=0xFFFFFF80. Same access as LBU -> rdata_o=0x00000080.
- SH addr 0x302, wdata_i=0x0000ABCD -> mem_wstrb_o=1100, mem_wdata_o=0xABCDABCD, mem_addr_o=0x300, mem_we_o=1.
- LW addr 0x101 -> mem_req_o never rises, err_o pulses one cycle, stall_o=0. Same for mem_read_i and mem_write_i both high.
- SW with ack delayed 3 cycles -> mem_req_o and all request fields stable for 4 BUSY cycles, stall_o high 5 cycles, DONE for 1 cycle, then IDLE.
- rst in second BUSY cycle, then ack the cycle after -> mem_req_o=0 after reset edge, FSM in IDLE, ack ignored, rdata_o=0.
